// File: rtl/delay_pkg.sv
// Shared helpers for the programmable delay line.
// Holds the ceiling-log2 used to size the select and history counters.
package delay_pkg;

  function automatic int clog2(input int value);
    int res;
    int v;
    res = 0;
    v   = value - 1;
    while (v > 0) begin
      res = res + 1;
      v   = v >> 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/programmable_delay_line.sv
// Tapped shift-register delay line with a registered tap select.
// Tracks how much genuine history is held so dout_valid can flag reset fill.
module programmable_delay_line
  import delay_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int DEPTH = 16,
  parameter int SELW  = clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             flush,
  input  logic [SELW-1:0]  delay_sel,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic             sel_err
);

  localparam int CW = clog2(DEPTH + 1);
  localparam logic [SELW-1:0] DEPTH_S = SELW'(DEPTH);
  localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [SELW-1:0]  active_sel_q;
  logic [SELW-1:0]  active_sel_d;
  logic             sel_err_q;
  logic             sel_err_d;
  logic [CW-1:0]    hist_cnt_q;
  logic [CW-1:0]    hist_cnt_d;
  logic [WIDTH-1:0] tap;

  always_comb begin
    sel_err_d    = (delay_sel > DEPTH_S);
    active_sel_d = sel_err_d ? DEPTH_S : delay_sel;
  end

  // Flush wins over en, so a sample arriving with flush is dropped.
  always_comb begin
    hist_cnt_d = hist_cnt_q;
    if (flush) begin
      hist_cnt_d = '0;
    end else if (en && (hist_cnt_q < DEPTH_C)) begin
      hist_cnt_d = hist_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      active_sel_q <= '0;
      sel_err_q    <= 1'b0;
      hist_cnt_q   <= '0;
    end else begin
      active_sel_q <= active_sel_d;
      sel_err_q    <= sel_err_d;
      hist_cnt_q   <= hist_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else if (en) begin
      stage_q[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  // Decoded tap mux keeps the index width independent of SELW.
  always_comb begin
    tap = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (active_sel_q == SELW'(i + 1)) begin
        tap = stage_q[i];
      end
    end
  end

  assign dout       = (active_sel_q == '0) ? din : tap;
  assign dout_valid = (32'(hist_cnt_q) >= 32'(active_sel_q));
  assign sel_err    = sel_err_q;

endmodule
